// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus, with per-master lock for atomic sequences.
// Define ARB_TIMEOUT_EN to add the slave timeout (TIMEOUT cycles, aborts with bus_err and all-ones data).
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dout,
    output logic [31:0] m0_din,
    input  logic        m0_wr,
    input  logic [3:0]  m0_lane,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic        m0_lock,

    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dout,
    output logic [31:0] m1_din,
    input  logic        m1_wr,
    input  logic [3:0]  m1_lane,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic        m1_lock,

    output logic [31:0] s_addr,
    output logic [31:0] s_dout,
    input  logic [31:0] s_din,
    output logic        s_wr,
    output logic [3:0]  s_lane,
    output logic        s_valid,
    input  logic        s_ready,

    output logic        grant,
    output logic        bus_err
);

    // state  | meaning
    // IDLE   | no owner; arbitrate between m0 and m1 each cycle
    // BUSY   | request registered on s_*, waiting for s_ready
    // LOCKED | granted master keeps the bus between transfers
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        start;
    logic        win;
    logic        g_valid;
    logic        g_lock;
    logic        tmo_hit;
    logic        done;
    logic [31:0] ret_data;

    always_comb begin
        g_valid = grant ? m1_valid : m0_valid;
        g_lock  = grant ? m1_lock  : m0_lock;
        start   = 1'b0;
        win     = grant;
        case (state)
            IDLE: begin
                start = m0_valid | m1_valid;
                if (m0_valid && m1_valid)
                    win = ~last_grant;
                else
                    win = m1_valid;
            end
            LOCKED: begin
                start = g_valid;
                win   = grant;
            end
            default: ;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    // Down-counter loaded on grant; terminal count in BUSY cycle TIMEOUT.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (start)
            tmo_cnt <= TW'(TIMEOUT - 1);
        else if (state == BUSY && !s_ready && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - TW'(1);
    end

    assign tmo_hit = (state == BUSY) && !s_ready && (tmo_cnt == '0);
`else
    // No counter: TIMEOUT is inert and this comparison is constant false.
    assign tmo_hit = (TIMEOUT < 0);
`endif

    assign done     = (state == BUSY) && (s_ready || tmo_hit);
    assign ret_data = tmo_hit ? 32'hFFFF_FFFF : s_din;
    assign bus_err  = tmo_hit;

    assign m0_ready = done && !grant;
    assign m1_ready = done &&  grant;
    assign m0_din   = (state == BUSY && !grant) ? ret_data : 32'h0;
    assign m1_din   = (state == BUSY &&  grant) ? ret_data : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            s_valid    <= 1'b0;
            s_wr       <= 1'b0;
            s_lane     <= 4'h0;
            s_addr     <= 32'h0;
            s_dout     <= 32'h0;
        end else begin
            case (state)
                IDLE, LOCKED: begin
                    if (start) begin
                        state      <= BUSY;
                        grant      <= win;
                        last_grant <= win;
                        s_valid    <= 1'b1;
                        s_addr     <= win ? m1_addr : m0_addr;
                        s_dout     <= win ? m1_dout : m0_dout;
                        s_wr       <= win ? m1_wr   : m0_wr;
                        s_lane     <= win ? m1_lane : m0_lane;
                    end else if (state == LOCKED && !g_lock) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    // A timeout also drops any lock the owner was holding.
                    if (tmo_hit) begin
                        s_valid <= 1'b0;
                        state   <= IDLE;
                    end else if (s_ready) begin
                        s_valid <= 1'b0;
                        state   <= g_lock ? LOCKED : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed test-plan scenarios, then random traffic against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_addr [2];
    logic [31:0] m_dout [2];
    logic        m_wr   [2];
    logic [3:0]  m_lane [2];
    logic        m_valid[2];
    logic        m_lock [2];
    logic [31:0] m0_din, m1_din;
    logic        m0_ready, m1_ready;
    logic [31:0] s_addr, s_dout, s_din;
    logic        s_wr, s_valid, s_ready;
    logic [3:0]  s_lane;
    logic        grant, bus_err;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m_addr[0]), .m0_dout(m_dout[0]), .m0_din(m0_din), .m0_wr(m_wr[0]),
        .m0_lane(m_lane[0]), .m0_valid(m_valid[0]), .m0_ready(m0_ready), .m0_lock(m_lock[0]),
        .m1_addr(m_addr[1]), .m1_dout(m_dout[1]), .m1_din(m1_din), .m1_wr(m_wr[1]),
        .m1_lane(m_lane[1]), .m1_valid(m_valid[1]), .m1_ready(m1_ready), .m1_lock(m_lock[1]),
        .s_addr(s_addr), .s_dout(s_dout), .s_din(s_din), .s_wr(s_wr), .s_lane(s_lane),
        .s_valid(s_valid), .s_ready(s_ready), .grant(grant), .bus_err(bus_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference: who owns the bus, what request is on it, who holds a lock, who won last.
    bit          mdl_busy;
    int          mdl_hold;
    int          mdl_own;
    int          mdl_last;
    int          mdl_age;
    logic [31:0] mdl_addr, mdl_dout;
    logic        mdl_wr;
    logic [3:0]  mdl_lane;
    bit          mdl_done[2];

    bit sl_active;
    int sl_wait;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mdl_expire();
`ifdef ARB_TIMEOUT_EN
        return mdl_busy && (mdl_age == TMO) && !s_ready;
`else
        return 1'b0;
`endif
    endfunction

    task automatic mdl_start(input int w);
        mdl_busy = 1;
        mdl_own  = w;
        mdl_last = w;
        mdl_hold = -1;
        mdl_age  = 1;
        mdl_addr = m_addr[w];
        mdl_dout = m_dout[w];
        mdl_wr   = m_wr[w];
        mdl_lane = m_lane[w];
    endtask

    task automatic mdl_step();
        bit ex;
        ex = mdl_expire();
        if (!rst_n) begin
            mdl_busy = 0; mdl_hold = -1; mdl_own = 0; mdl_last = 1; mdl_age = 0;
            mdl_addr = '0; mdl_dout = '0; mdl_wr = 1'b0; mdl_lane = '0;
        end else if (mdl_busy) begin
            if (s_ready || ex) begin
                mdl_busy = 0;
                mdl_hold = (s_ready && m_lock[mdl_own]) ? mdl_own : -1;
            end else begin
                mdl_age++;
            end
        end else if (mdl_hold >= 0) begin
            if (m_valid[mdl_hold])
                mdl_start(mdl_hold);
            else if (!m_lock[mdl_hold])
                mdl_hold = -1;
        end else if (m_valid[0] && m_valid[1]) begin
            mdl_start(1 - mdl_last);
        end else if (m_valid[0]) begin
            mdl_start(0);
        end else if (m_valid[1]) begin
            mdl_start(1);
        end
    endtask

    task automatic check_all();
        bit          ex;
        logic [31:0] rd;
        ex = mdl_expire();
        rd = ex ? 32'hFFFF_FFFF : s_din;
        check_val("s_valid", 32'(s_valid), 32'(mdl_busy));
        check_val("s_addr", s_addr, mdl_addr);
        check_val("s_dout", s_dout, mdl_dout);
        check_val("s_wr", 32'(s_wr), 32'(mdl_wr));
        check_val("s_lane", 32'(s_lane), 32'(mdl_lane));
        check_val("grant", 32'(grant), 32'(mdl_own));
        check_val("bus_err", 32'(bus_err), 32'(ex));
        for (int i = 0; i < 2; i++) begin
            bit owner;
            owner       = mdl_busy && (mdl_own == i);
            mdl_done[i] = owner && (s_ready || ex);
            check_val($sformatf("m%0d_ready", i), 32'(i == 0 ? m0_ready : m1_ready), 32'(mdl_done[i]));
            check_val($sformatf("m%0d_din", i), i == 0 ? m0_din : m1_din, owner ? rd : 32'h0);
        end
    endtask

    task automatic half_neg();
        @(negedge clk);
        check_all();
    endtask

    task automatic half_pos();
        @(posedge clk);
        mdl_step();
        #1;
    endtask

    task automatic run_cycle();
        half_neg();
        half_pos();
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_lock[i] = 0; m_wr[i] = 0;
            m_lane[i] = 4'hF; m_addr[i] = '0; m_dout[i] = '0;
        end
        s_ready = 0;
        s_din   = '0;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && (m_valid[0] || m_valid[1] || mdl_busy); c++) begin
            s_ready = mdl_busy;
            s_din   = $urandom;
            run_cycle();
            for (int i = 0; i < 2; i++)
                if (mdl_done[i]) m_valid[i] = 0;
        end
        s_ready = 0;
    endtask

    task automatic agents();
        rst_n = ($urandom_range(0, 149) != 0);
        for (int i = 0; i < 2; i++) begin
            if (mdl_done[i]) m_valid[i] = 0;
            if (!m_valid[i] && m_lock[i] && $urandom_range(0, 1) == 0) m_lock[i] = 0;
            if (!m_valid[i] && $urandom_range(0, 2) == 0) begin
                m_valid[i] = 1;
                m_addr[i]  = $urandom;
                m_dout[i]  = $urandom;
                m_wr[i]    = 1'($urandom_range(0, 1));
                m_lane[i]  = 4'($urandom_range(1, 15));
                m_lock[i]  = ($urandom_range(0, 3) == 0);
            end
        end
        s_din   = $urandom;
        s_ready = 0;
        if (mdl_busy) begin
            if (!sl_active) begin
                sl_active = 1;
                sl_wait   = $urandom_range(0, 3);
            end
            if (sl_wait == 0) begin
                s_ready   = 1;
                sl_active = 0;
            end else begin
                sl_wait--;
            end
        end else begin
            sl_active = 0;
            s_ready   = ($urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        int lock_exp[3];
        lock_exp[0] = 0; lock_exp[1] = 0; lock_exp[2] = 1;
        sl_active = 0;
        sl_wait   = 0;
        rst_n = 0;
        idle_inputs();
        half_pos();
        half_neg();
        check_val("rst_s_valid", 32'(s_valid), 32'h0);
        check_val("rst_grant", 32'(grant), 32'h0);
        check_val("rst_s_addr", s_addr, 32'h0);
        half_pos();

        // Single master read: s_valid one cycle after request, ready with data on s_ready.
        rst_n = 1;
        m_valid[0] = 1; m_addr[0] = 32'h100; m_wr[0] = 0;
        run_cycle();
        check_val("rd_s_valid", 32'(s_valid), 32'h1);
        check_val("rd_s_addr", s_addr, 32'h100);
        run_cycle();
        s_ready = 1; s_din = 32'hDEADBEEF;
        half_neg();
        check_val("rd_ready", 32'(m0_ready), 32'h1);
        check_val("rd_din", m0_din, 32'hDEADBEEF);
        half_pos();
        s_ready = 0; m_valid[0] = 0;
        run_cycle();

        // Contention after reset: 0,1,0,1.
        rst_n = 0;
        run_cycle();
        rst_n = 1;
        m_valid[0] = 1; m_addr[0] = 32'h1000;
        m_valid[1] = 1; m_addr[1] = 32'h2000; m_wr[1] = 0; m_lane[1] = 4'hF;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            s_ready = mdl_busy; s_din = $urandom;
            half_neg();
            w = -1;
            if (mdl_done[0] || mdl_done[1]) begin
                w = mdl_done[1] ? 1 : 0;
                check_val($sformatf("cont_grant%0d", n), 32'(grant), 32'(n % 2));
                check_val($sformatf("cont_addr%0d", n), s_addr,
                          ((n % 2) ? 32'h2000 : 32'h1000) + 32'(4 * (n / 2)));
                n++;
            end
            half_pos();
            if (w >= 0) m_addr[w] = m_addr[w] + 32'd4;
        end
        check_val("cont_count", 32'(n), 32'd4);
        m_valid[0] = 0; m_valid[1] = 0; s_ready = 0;
        run_cycle();

        // Lock: m0 read+write of 0x40 stay indivisible while m1 waits.
        m_valid[1] = 1; m_addr[1] = 32'h3000;
        m_valid[0] = 1; m_lock[0] = 1; m_addr[0] = 32'h40; m_wr[0] = 0;
        n = 0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            s_ready = mdl_busy; s_din = $urandom;
            half_neg();
            w = -1;
            if (mdl_done[0] || mdl_done[1]) begin
                w = mdl_done[1] ? 1 : 0;
                check_val($sformatf("lock_seq%0d", n), 32'(w), 32'(lock_exp[n]));
                n++;
            end
            half_pos();
            if (w == 0 && n == 1) begin
                m_wr[0] = 1; m_dout[0] = 32'h11;
            end else if (w == 0) begin
                m_valid[0] = 0;
            end else if (w == 1) begin
                m_valid[1] = 0;
            end else if (n == 2 && !m_valid[0]) begin
                m_lock[0] = 0;
            end
        end
        check_val("lock_count", 32'(n), 32'd3);
        s_ready = 0;
        run_cycle();

        // Byte write from m1: s_* held for the whole BUSY period even if inputs move.
        m_valid[1] = 1; m_wr[1] = 1; m_lane[1] = 4'b0100; m_dout[1] = 32'h5A5A5A5A; m_addr[1] = 32'h80;
        run_cycle();
        m_dout[1] = 32'h0; m_lane[1] = 4'hF; m_wr[1] = 0;
        for (int k = 0; k < 4; k++) begin
            s_ready = (k == 3);
            half_neg();
            check_val("bw_lane", 32'(s_lane), 32'h4);
            check_val("bw_wr", 32'(s_wr), 32'h1);
            check_val("bw_dout", s_dout, 32'h5A5A5A5A);
            check_val("bw_ready", 32'(m1_ready), 32'(k == 3));
            half_pos();
        end
        m_valid[1] = 0; s_ready = 0;
        run_cycle();

        // Reset during BUSY, then m0 wins the first contested grant.
        m_valid[0] = 1; m_addr[0] = 32'h200; m_wr[0] = 0; m_lane[0] = 4'hF;
        run_cycle();
        run_cycle();
        rst_n = 0;
        run_cycle();
        check_val("rmid_s_valid", 32'(s_valid), 32'h0);
        rst_n = 1;
        m_valid[1] = 1; m_addr[1] = 32'h300;
        run_cycle();
        check_val("rmid_grant", 32'(grant), 32'h0);
        check_val("rmid_s_addr", s_addr, 32'h200);
        drain();

`ifdef ARB_TIMEOUT_EN
        // Silent slave: abort in BUSY cycle TMO; lock is dropped by the abort.
        m_valid[0] = 1; m_lock[0] = 1; m_addr[0] = 32'h400;
        run_cycle();
        for (int k = 1; k <= TMO; k++) begin
            s_ready = 0;
            half_neg();
            check_val($sformatf("tmo_ready%0d", k), 32'(m0_ready), 32'(k == TMO));
            check_val($sformatf("tmo_err%0d", k), 32'(bus_err), 32'(k == TMO));
            if (k == TMO) check_val("tmo_din", m0_din, 32'hFFFFFFFF);
            half_pos();
        end
        m_valid[0] = 0;
        m_valid[1] = 1; m_addr[1] = 32'h500;
        drain();
        m_lock[0] = 0;
        m_valid[0] = 1; m_addr[0] = 32'h404;
        run_cycle();
        for (int k = 1; k <= TMO; k++) begin
            s_ready = (k == TMO); s_din = 32'h12345678;
            half_neg();
            if (k == TMO) begin
                check_val("tmo_late_err", 32'(bus_err), 32'h0);
                check_val("tmo_late_ready", 32'(m0_ready), 32'h1);
                check_val("tmo_late_din", m0_din, 32'h12345678);
            end
            half_pos();
        end
        m_valid[0] = 0; s_ready = 0;
        run_cycle();
`endif

        // Random traffic, random latency, stray s_ready and occasional reset.
        idle_inputs();
        for (int c = 0; c < 4000; c++) begin
            run_cycle();
            agents();
        end
        rst_n = 1;
        run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
